xbar_mac_sequencer: RTL and testbench

Controller and row-sequential compute engine for the 4x8 crossbar weighted-sum array. Holds a 4-row x 8-column 4-bit weight matrix loaded by row writes. Accepts a 4-element input vector over a valid/ready handshake and walks the rows one per cycle, accumulating 8 column sums. Presents all 8 sums over a valid/ready output handshake. Sits between the host/loader and downstream consumers of the column weighted sums.

---
 rtl/xbar_pkg.sv | 18 +
 rtl/xbar_row_mac.sv | 35 +++
 rtl/xbar_mac_sequencer.sv | 93 +++++++++
 tb/tb_xbar_mac_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared sizes, FSM state encoding and bus types for the 4x8 crossbar weighted-sum sequencer.
package xbar_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 8;
    localparam int unsigned DW   = 4;
    localparam int unsigned SW   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [COLS*DW-1:0] row_word_t;
    typedef logic [COLS*SW-1:0] sum_vec_t;

endpackage

// File: rtl/xbar_row_mac.sv
// Eight parallel unsigned DW x DW multipliers feeding eight SW-bit accumulators.
module xbar_row_mac
    import xbar_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  row_word_t     row,
    output sum_vec_t      sums
);

    logic [2*DW-1:0] prod [COLS];

    always_comb begin
        for (int unsigned j = 0; j < COLS; j++) begin
            prod[j] = {{DW{1'b0}}, a} * {{DW{1'b0}}, row[j*DW +: DW]};
        end
    end

    // Slice j of the row word and of the sum vector refer to the same column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sums <= '0;
        end else if (clr) begin
            sums <= '0;
        end else if (en) begin
            for (int unsigned j = 0; j < COLS; j++) begin
                sums[j*SW +: SW] <= sums[j*SW +: SW] + {{(SW-2*DW){1'b0}}, prod[j]};
            end
        end
    end

endmodule

// File: rtl/xbar_mac_sequencer.sv
// Crossbar controller: weight register file, row-walking FSM and in/out handshakes.
module xbar_mac_sequencer
    import xbar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           wr_row,
    input  logic [COLS*DW-1:0]   wr_data,
    output logic                 wr_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS*SW-1:0]   out_sums,
    output logic                 busy
);

    localparam int unsigned      RCW      = $clog2(ROWS);
    localparam logic [RCW-1:0]   LAST_ROW = RCW'(ROWS - 1);

    state_t          state, next_state;
    logic [RCW-1:0]  row_cnt;
    logic [DW-1:0]   vec_q   [ROWS];
    row_word_t       weights [ROWS];
    logic            clr, en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        clr        = 1'b0;
        en         = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = ACC;
                    clr        = 1'b1;
                end
            end
            ACC: begin
                en = 1'b1;
                if (row_cnt == LAST_ROW) next_state = DONE;
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACC);

    // Element r1 sits in the top nibble of in_vec and pairs with weight row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            for (int unsigned r = 0; r < ROWS; r++) vec_q[r] <= '0;
        end else if (clr) begin
            row_cnt <= '0;
            for (int unsigned r = 0; r < ROWS; r++) vec_q[r] <= in_vec[(ROWS-1-r)*DW +: DW];
        end else if (en) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
            for (int unsigned r = 0; r < ROWS; r++) weights[r] <= '0;
        end else begin
            wr_err <= wr_en && (state == ACC);
            if (wr_en && (state != ACC)) weights[wr_row] <= wr_data;
        end
    end

    xbar_row_mac u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .a    (vec_q[row_cnt]),
        .row  (weights[row_cnt]),
        .sums (out_sums)
    );

endmodule

// File: tb/tb_xbar_mac_sequencer.sv
// Self-checking bench for xbar_mac_sequencer against a matrix-product reference model.
module tb_xbar_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_row = '0;
    logic [31:0] wr_data = '0;
    logic        wr_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [95:0] out_sums;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int wm [4][8];

    xbar_mac_sequencer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_err(wr_err), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_sums(out_sums), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) wm[r][c] = 0;
    endfunction

    function automatic void model_write(input int row, input logic [31:0] data);
        for (int c = 0; c < 8; c++) wm[row][c] = int'((data >> (28 - 4*c)) & 32'hF);
    endfunction

    // Column c (0 = column 1) of the result is sum_r r_elem * w[r][c].
    function automatic logic [95:0] model_sums(input logic [15:0] v);
        logic [95:0] e;
        int s;
        e = '0;
        for (int c = 0; c < 8; c++) begin
            s = 0;
            for (int r = 0; r < 4; r++) s += int'((v >> (12 - 4*r)) & 16'hF) * wm[r][c];
            e |= 96'(s) << (84 - 12*c);
        end
        return e;
    endfunction

    task automatic write_row(input logic [1:0] row, input logic [31:0] data);
        wr_en = 1'b1; wr_row = row; wr_data = data;
        tick();
        wr_en = 1'b0;
        model_write(int'(row), data);
    endtask

    task automatic do_op(input logic [15:0] v, output int lat, output int busy_cnt);
        in_vec = v; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; wr_en = 1'b0;
        in_vec = 16'($urandom);
        lat = 0; busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        int lat, bc;
        write_row(2'd0, 32'hFFFF_FFFF);
        do_op(16'hF000, lat, bc);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_sums !== 96'd0) begin n_err++; $display("FAIL reset_out_sums got %h want 0", out_sums); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0 || wr_err !== 1'b0) begin n_err++; $display("FAIL reset_busy_wr_err got %b%b want 00", busy, wr_err); end
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_full_scale;
        int lat, bc;
        for (int r = 0; r < 4; r++) write_row(2'(r), 32'hFFFF_FFFF);
        do_op(16'hFFFF, lat, bc);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL full_latency got %0d want 4", lat); end
        n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL full_busy_cycles got %0d want 4", bc); end
        n_cmp++; if (out_sums !== {8{12'h384}}) begin n_err++; $display("FAIL full_sums got %h want %h", out_sums, {8{12'h384}}); end
        consume();
    endtask

    task automatic test_single_row;
        int lat, bc;
        write_row(2'd0, 32'h1234_5678);
        for (int r = 1; r < 4; r++) write_row(2'(r), 32'h0);
        do_op(16'h2000, lat, bc);
        n_cmp++;
        if (out_sums !== {12'd2, 12'd4, 12'd6, 12'd8, 12'd10, 12'd12, 12'd14, 12'd16}) begin
            n_err++; $display("FAIL single_row_scale got %h", out_sums);
        end
        consume();
        do_op(16'h0FFF, lat, bc);
        n_cmp++; if (out_sums !== 96'd0 || lat !== 4) begin n_err++; $display("FAIL single_row_zero got %h lat %0d want 0 lat 4", out_sums, lat); end
        consume();
    endtask

    task automatic test_backpressure;
        int lat, bc;
        logic [15:0] v;
        logic [95:0] exp;
        for (int r = 0; r < 4; r++) write_row(2'(r), $urandom);
        v = 16'($urandom);
        exp = model_sums(v);
        do_op(v, lat, bc);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sums !== exp) begin
                n_err++; $display("FAIL backpressure_hold cyc %0d got v%b r%b %h want v1 r0 %h", i, out_valid, in_ready, out_sums, exp);
            end
            in_valid = 1'b1; in_vec = 16'($urandom);
            wr_en = (i == 3); wr_row = 2'd2; wr_data = $urandom;
            tick();
            if (i == 3) model_write(2, wr_data);
            wr_en = 1'b0;
        end
        in_valid = 1'b0;
        consume();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL backpressure_release got r%b v%b want r1 v0", in_ready, out_valid); end
        v = 16'($urandom);
        do_op(v, lat, bc);
        n_cmp++; if (out_sums !== model_sums(v) || lat !== 4) begin n_err++; $display("FAIL backpressure_next got %h want %h", out_sums, model_sums(v)); end
        consume();
    endtask

    task automatic test_write_during_acc;
        int lat, bc;
        logic [15:0] v;
        logic [95:0] exp;
        for (int r = 0; r < 4; r++) write_row(2'(r), $urandom & 32'h7777_7777);
        v = 16'($urandom) | 16'h0100;
        exp = model_sums(v);
        in_vec = v; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        wr_en = 1'b1; wr_row = 2'd1; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL acc_write_err_pulse got %b want 1", wr_err); end
        tick();
        n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL acc_write_err_clear got %b want 0", wr_err); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_sums !== exp) begin n_err++; $display("FAIL acc_write_old_weights got v%b %h want v1 %h", out_valid, out_sums, exp); end
        consume();
        do_op(v, lat, bc);
        n_cmp++; if (out_sums !== exp) begin n_err++; $display("FAIL acc_write_row1_kept got %h want %h", out_sums, exp); end
        consume();
    endtask

    task automatic test_reset_mid_acc;
        int lat, bc;
        in_vec = 16'hFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_sums !== 96'd0) begin
            n_err++; $display("FAIL mid_acc_reset got v%b b%b r%b %h want v0 b0 r1 0", out_valid, busy, in_ready, out_sums);
        end
        tick();
        rst = 1'b0;
        model_clear();
        for (int r = 0; r < 4; r++) write_row(2'(r), 32'h1000_0000 >> (4*r));
        do_op(16'h1234, lat, bc);
        n_cmp++;
        if (out_sums !== {12'd1, 12'd2, 12'd3, 12'd4, 48'd0} || out_sums !== model_sums(16'h1234)) begin
            n_err++; $display("FAIL mid_acc_identity got %h want %h", out_sums, {12'd1, 12'd2, 12'd3, 12'd4, 48'd0});
        end
        consume();
    endtask

    task automatic test_random;
        int lat, bc, d;
        logic [15:0] v;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) write_row(2'($urandom_range(0, 3)), $urandom);
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wr_en = 1'b1; wr_row = 2'($urandom_range(0, 3)); wr_data = $urandom;
                model_write(int'(wr_row), wr_data);
            end
            do_op(v, lat, bc);
            n_cmp++;
            if (out_sums !== model_sums(v) || lat !== 4) begin
                n_err++; $display("FAIL random_op it %0d got %h lat %0d want %h lat 4", it, out_sums, lat, model_sums(v));
            end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) tick();
            consume();
        end
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_full_scale();
        test_single_row();
        test_backpressure();
        test_write_during_acc();
        test_reset_mid_acc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
